// File: rtl/mdu_ctrl_pkg.sv
// Shared types and constants for the multiply/divide unit.
// Imported by the MDU controller, its arithmetic block, decoder and hazard unit.
package mdu_ctrl_pkg;

    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5
    } md_op_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } mdu_state_t;

    localparam int DEF_MULT_CYCLES = 5;
    localparam int DEF_DIV_CYCLES  = 10;

    // True for the ops that occupy the unit for a multi-cycle window.
    function automatic logic is_long_op(md_op_t op);
        return (op == MD_MULT) || (op == MD_MULTU) ||
               (op == MD_DIV)  || (op == MD_DIVU);
    endfunction

    function automatic logic is_div_op(md_op_t op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/mdu_ctrl_arith.sv
// md_arith: combinational 64-bit HI/LO result generator for the MDU.
// Ports: i_op (md_op_t), i_a/i_b operands -> o_res_hi, o_res_lo, o_div0.
module md_arith
    import mdu_ctrl_pkg::*;
(
    input  md_op_t      i_op,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic [31:0] o_res_hi,
    output logic [31:0] o_res_lo,
    output logic        o_div0
);

    logic        w_sgn;
    logic [63:0] w_a64;
    logic [63:0] w_b64;
    logic [63:0] w_prod;
    logic        w_a_neg;
    logic        w_b_neg;
    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic [31:0] w_b_safe;
    logic [31:0] w_q_mag;
    logic [31:0] w_r_mag;
    logic [31:0] w_q;
    logic [31:0] w_r;

    assign w_sgn = (i_op == MD_MULT) || (i_op == MD_DIV);

    // Low 64 bits of a 64x64 product of extended operands is the
    // correct signed or unsigned 32x32 product.
    assign w_a64  = {{32{w_sgn & i_a[31]}}, i_a};
    assign w_b64  = {{32{w_sgn & i_b[31]}}, i_b};
    assign w_prod = w_a64 * w_b64;

    // Sign-magnitude divide. |0x80000000| stays 0x80000000 as an
    // unsigned magnitude, so the overflow case yields q=0x80000000, r=0.
    assign w_a_neg  = w_sgn & i_a[31];
    assign w_b_neg  = w_sgn & i_b[31];
    assign w_a_mag  = w_a_neg ? (~i_a + 32'd1) : i_a;
    assign w_b_mag  = w_b_neg ? (~i_b + 32'd1) : i_b;
    assign w_b_safe = (w_b_mag == 32'd0) ? 32'd1 : w_b_mag;
    assign w_q_mag  = w_a_mag / w_b_safe;
    assign w_r_mag  = w_a_mag % w_b_safe;
    assign w_q      = (w_a_neg ^ w_b_neg) ? (~w_q_mag + 32'd1) : w_q_mag;
    assign w_r      = w_a_neg ? (~w_r_mag + 32'd1) : w_r_mag;

    always_comb begin
        o_res_hi = 32'd0;
        o_res_lo = 32'd0;
        o_div0   = 1'b0;
        unique case (i_op)
            MD_MULT, MD_MULTU: begin
                o_res_hi = w_prod[63:32];
                o_res_lo = w_prod[31:0];
            end
            MD_DIV, MD_DIVU: begin
                o_res_hi = w_r;
                o_res_lo = w_q;
                o_div0   = (i_b == 32'd0);
            end
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: multi-cycle MULT/DIV sequencer with HI/LO registers (E stage).
// Ports: clk, reset, start, op, a, b, flush in; busy, hi, lo out (registered).
module mdu_ctrl
    import mdu_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = DEF_MULT_CYCLES,
    parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  md_op_t      op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        flush,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    mdu_state_t  r_state;
    logic [CW-1:0] r_cnt;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic [31:0] r_pend_hi;
    logic [31:0] r_pend_lo;
    logic        r_pend_div0;

    mdu_state_t  w_state_nxt;
    logic [CW-1:0] w_cnt_nxt;
    logic [31:0] w_hi_nxt;
    logic [31:0] w_lo_nxt;
    logic [31:0] w_pend_hi_nxt;
    logic [31:0] w_pend_lo_nxt;
    logic        w_pend_div0_nxt;

    logic        w_accept;
    logic [31:0] w_res_hi;
    logic [31:0] w_res_lo;
    logic        w_div0;

    md_arith u_arith (
        .i_op     (op),
        .i_a      (a),
        .i_b      (b),
        .o_res_hi (w_res_hi),
        .o_res_lo (w_res_lo),
        .o_div0   (w_div0)
    );

    assign w_accept = start & ~flush & (r_state == ST_IDLE);

    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_hi_nxt        = r_hi;
        w_lo_nxt        = r_lo;
        w_pend_hi_nxt   = r_pend_hi;
        w_pend_lo_nxt   = r_pend_lo;
        w_pend_div0_nxt = r_pend_div0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (is_long_op(op)) begin
                        w_pend_hi_nxt   = w_res_hi;
                        w_pend_lo_nxt   = w_res_lo;
                        w_pend_div0_nxt = w_div0;
                        w_cnt_nxt       = is_div_op(op) ? CW'(DIV_CYCLES)
                                                        : CW'(MULT_CYCLES);
                        w_state_nxt     = ST_BUSY;
                    end else if (op == MD_MTHI) begin
                        w_hi_nxt = a;
                    end else if (op == MD_MTLO) begin
                        w_lo_nxt = a;
                    end
                end
            end
            ST_BUSY: begin
                w_cnt_nxt = r_cnt - CW'(1);
                if (r_cnt == CW'(1)) begin
                    // Divide by zero leaves HI/LO untouched at commit.
                    if (!r_pend_div0) begin
                        w_hi_nxt = r_pend_hi;
                        w_lo_nxt = r_pend_lo;
                    end
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_hi        <= 32'd0;
            r_lo        <= 32'd0;
            r_pend_hi   <= 32'd0;
            r_pend_lo   <= 32'd0;
            r_pend_div0 <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_hi        <= w_hi_nxt;
            r_lo        <= w_lo_nxt;
            r_pend_hi   <= w_pend_hi_nxt;
            r_pend_lo   <= w_pend_lo_nxt;
            r_pend_div0 <= w_pend_div0_nxt;
        end
    end

    assign busy = (r_state == ST_BUSY);
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Testbench for mdu_ctrl: directed plus randomized ops against a
// behavioural HI/LO model using 64-bit integer arithmetic.
module tb_mdu_ctrl;
    import mdu_ctrl_pkg::*;

    localparam int NM = 5;
    localparam int ND = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        flush;
    md_op_t      op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int          n_cmp  = 0;
    int          n_fail = 0;
    logic [31:0] m_hi   = 32'd0;
    logic [31:0] m_lo   = 32'd0;

    always #5 clk = ~clk;

    mdu_ctrl #(.MULT_CYCLES(NM), .DIV_CYCLES(ND)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .flush (flush),
        .busy  (busy),
        .hi    (hi),
        .lo    (lo)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic exp_busy);
        chk({tag, "_busy"}, 32'(busy), 32'(exp_busy));
        chk({tag, "_hi"}, hi, m_hi);
        chk({tag, "_lo"}, lo, m_lo);
    endtask

    // Architectural effect of one accepted op on HI/LO.
    function automatic void ref_exec(input md_op_t o, input logic [31:0] xa,
                                     input logic [31:0] xb);
        longint          sa;
        longint          sb;
        longint unsigned ua;
        longint unsigned ub;
        longint          sp;
        longint unsigned up;
        sa = longint'($signed(xa));
        sb = longint'($signed(xb));
        ua = {32'd0, xa};
        ub = {32'd0, xb};
        case (o)
            MD_MULT: begin
                sp = sa * sb;
                m_hi = sp[63:32];
                m_lo = sp[31:0];
            end
            MD_MULTU: begin
                up = ua * ub;
                m_hi = up[63:32];
                m_lo = up[31:0];
            end
            MD_DIV: if (xb != 32'd0) begin
                m_lo = 32'(sa / sb);
                m_hi = 32'(sa % sb);
            end
            MD_DIVU: if (xb != 32'd0) begin
                m_lo = 32'(ua / ub);
                m_hi = 32'(ua % ub);
            end
            MD_MTHI: m_hi = xa;
            MD_MTLO: m_lo = xa;
            default: begin
            end
        endcase
    endfunction

    // Long op: busy for exactly n cycles with old HI/LO, then new values.
    // fl_at / st_at inject flush or a start(MTLO) in that busy cycle.
    task automatic run_op(input md_op_t o, input logic [31:0] xa,
                          input logic [31:0] xb, input int fl_at,
                          input int st_at, input string tag);
        int n;
        n = (o == MD_DIV || o == MD_DIVU) ? ND : NM;
        start = 1'b1;
        op    = o;
        a     = xa;
        b     = xb;
        flush = 1'b0;
        tick();
        start = 1'b0;
        for (int i = 0; i < n; i++) begin
            chk_all(tag, 1'b1);
            flush = (i == fl_at);
            if (i == st_at) begin
                start = 1'b1;
                op    = MD_MTLO;
                a     = 32'hDEAD_0000;
            end else begin
                start = 1'b0;
            end
            tick();
        end
        start = 1'b0;
        flush = 1'b0;
        ref_exec(o, xa, xb);
        chk_all({tag, "_done"}, 1'b0);
    endtask

    task automatic issue_short(input md_op_t o, input logic [31:0] xa,
                               input logic fl, input string tag);
        start = 1'b1;
        op    = o;
        a     = xa;
        flush = fl;
        tick();
        start = 1'b0;
        flush = 1'b0;
        if (!fl) ref_exec(o, xa, 32'd0);
        chk_all(tag, 1'b0);
    endtask

    task automatic issue_flushed_long(input md_op_t o, input logic [31:0] xa,
                                      input logic [31:0] xb, input string tag);
        start = 1'b1;
        op    = o;
        a     = xa;
        b     = xb;
        flush = 1'b1;
        tick();
        start = 1'b0;
        flush = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk_all(tag, 1'b0);
            tick();
        end
    endtask

    initial begin
        md_op_t      ro;
        logic [31:0] ra;
        logic [31:0] rb;
        logic        rf;
        int          sel;

        reset = 1'b1;
        start = 1'b0;
        flush = 1'b0;
        op    = MD_MULT;
        a     = 32'd0;
        b     = 32'd0;
        #3;
        chk_all("reset", 1'b0);
        tick();
        tick();
        reset = 1'b0;
        chk_all("post_reset", 1'b0);

        run_op(MD_MULT, 32'hFFFF_FFFF, 32'd2, -1, -1, "mult");
        chk("mult_hi_k", hi, 32'hFFFF_FFFF);
        chk("mult_lo_k", lo, 32'hFFFF_FFFE);
        run_op(MD_MULTU, 32'hFFFF_FFFF, 32'd2, -1, -1, "multu");
        chk("multu_hi_k", hi, 32'h0000_0001);
        chk("multu_lo_k", lo, 32'hFFFF_FFFE);
        run_op(MD_DIV, 32'hFFFF_FFF9, 32'd2, -1, -1, "div");
        chk("div_hi_k", hi, 32'hFFFF_FFFF);
        chk("div_lo_k", lo, 32'hFFFF_FFFD);
        run_op(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, -1, -1, "divovf");
        chk("divovf_hi_k", hi, 32'h0000_0000);
        chk("divovf_lo_k", lo, 32'h8000_0000);
        run_op(MD_DIVU, 32'd7, 32'd0, -1, -1, "divu0");
        chk("divu0_lo_k", lo, 32'h8000_0000);

        issue_short(MD_MTHI, 32'h0000_1234, 1'b0, "mthi");
        chk("mthi_k", hi, 32'h0000_1234);
        issue_short(MD_MTHI, 32'h0000_5678, 1'b1, "mthi_fl");
        chk("mthi_fl_k", hi, 32'h0000_1234);
        issue_short(MD_MTLO, 32'hCAFE_F00D, 1'b0, "mtlo");
        issue_flushed_long(MD_MULT, 32'd3, 32'd4, "mult_fl");

        run_op(MD_DIV, 32'd100, 32'd7, 2, -1, "div_flbusy");
        chk("div_flbusy_lo_k", lo, 32'd14);
        run_op(MD_MULT, 32'd12345, 32'd6789, -1, 1, "mult_stbusy");
        chk("mult_stbusy_lo_k", lo, 32'd83810205);

        run_op(MD_MULT, 32'h8000_0000, 32'h8000_0000, -1, -1, "b2b_mult");
        run_op(MD_DIV, 32'hFFFF_FF00, 32'd17, -1, -1, "b2b_div");

        for (int k = 0; k < 24; k++) begin
            ro  = md_op_t'(3'($urandom_range(0, 5)));
            ra  = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
            sel = $urandom_range(0, 7);
            rb  = (sel == 0) ? 32'd0 :
                  (sel == 1) ? 32'hFFFF_FFFF :
                  (sel == 2) ? 32'($urandom_range(1, 9)) : $urandom;
            rf  = ($urandom_range(0, 5) == 0);
            if (!is_long_op(ro))
                issue_short(ro, ra, rf, "rnd_short");
            else if (rf)
                issue_flushed_long(ro, ra, rb, "rnd_fl");
            else
                run_op(ro, ra, rb, -1, -1, "rnd_long");
        end

        issue_short(MD_MTHI, 32'h0000_0055, 1'b0, "pre_rst_hi");
        issue_short(MD_MTLO, 32'h0000_00AA, 1'b0, "pre_rst_lo");
        start = 1'b1;
        op    = MD_MULT;
        a     = 32'd3;
        b     = 32'd5;
        tick();
        start = 1'b0;
        chk_all("rst_c1", 1'b1);
        tick();
        #2;
        reset = 1'b1;
        #1;
        m_hi = 32'd0;
        m_lo = 32'd0;
        chk_all("rst_async", 1'b0);
        tick();
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk_all("rst_after", 1'b0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
